axi4_lite_reg_file: RTL and testbench
=====================================

# axi4_lite_reg_file

AXI4-Lite slave register bank that terminates the slave side of the AXI4-Lite master/slave adaptor pair. It consumes the adaptor's write-address, write-data and read-address channels, and produces the write-response and read-data channels. It holds NUM_REGS 32-bit registers with byte-strobe writes and reports out-of-range accesses with SLVERR. All register contents are exported in parallel for downstream logic.

## Interface
- NUM_REGS, 8: number of 32-bit registers; power of two, 2..256.
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- awaddr  in  32  write byte address.
- awprot  in  3  accepted and ignored.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  4  byte enables; bit i enables wdata[8i+7:8i].
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  32  read byte address.
- arprot  in  3  accepted and ignored.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- regs_flat  out  32*NUM_REGS  register k on bits [32k+31:32k]; registered, no extra delay.

## Operation
- Address decode:
  - word index = addr[31:2]; addr[1:0] ignored.
  - In range when word index < NUM_REGS; register selected = word index.
- Write path, states W_COLLECT and W_RESP:
  - W_COLLECT captures AW and W independently into holding registers, with flags aw_held and w_held.
  - awready = ~aw_held in W_COLLECT; wready = ~w_held in W_COLLECT.
  - Both awready and wready are 0 in W_RESP.
  - AW and W may arrive in either order or in the same cycle.
  - When both are held, or the second arrives, commit on the next edge:
    - Each byte with wstrb set is updated in the selected register.
    - bresp = OKAY if in range; otherwise SLVERR and no register changes.
    - bvalid = 1, flags clear, go to W_RESP.
  - W_RESP: bvalid and bresp hold stable until bvalid & bready. Then bvalid = 0 on that edge and return to W_COLLECT.
- Read path, states R_IDLE and R_RESP:
  - arready = 1 only in R_IDLE.
  - On arvalid & arready:
    - rdata = selected register and rresp = OKAY if in range.
    - Otherwise rdata = 0 and rresp = SLVERR.
    - rvalid = 1, go to R_RESP.
  - R_RESP: rdata, rresp and rvalid are stable until rvalid & rready, then return to R_IDLE.
- Read and write paths are fully independent and may be active concurrently.
- wstrb = 4'b0000 to an in-range address: OKAY response, no data change.

## Timing
- Reset values:
  - All registers 0.
  - awready, wready, arready, bvalid, rvalid all 0.
  - bresp, rresp, rdata all 0.
  - awready, wready and arready rise on the first edge after areset deasserts.
- Write latency:
  - bvalid rises 1 cycle after the edge completing the later of the AW and W handshakes. With simultaneous AW+W handshake at edge N, bvalid is high after edge N+1.
  - The register value is visible on regs_flat in the same cycle bvalid rises.
- Write throughput: with bready tied high, one write per 3 cycles.
  - Sequence: handshake, commit, response handshake; awready/wready are high again the cycle after the response handshake.
- Read latency: rvalid high the cycle after the AR handshake.
- Read throughput: with rready high, one read per 2 cycles.
- Read/write collision: rdata is sampled on the AR-handshake edge. If a write commits to the same register on that edge, rdata returns the pre-write value.
- Backpressure: bvalid/rvalid held indefinitely; no new AW/W/AR is accepted on that path meanwhile.
- areset mid-transaction:
  - Held AW/W data and pending responses are discarded.
  - All outputs return to reset values on that edge.
  - No partial register write occurs.

## Test plan
- Reset, then write 0xDEADBEEF to 0x04 with wstrb=4'hF (AW+W same cycle), bready=1 -> bvalid after 1 cycle, bresp=00. Read 0x04 -> rdata=0xDEADBEEF, rresp=00; regs_flat[63:32]=0xDEADBEEF.
- Byte strobes: reg 0 = 0x11223344, then write 0xAABBCCDD with wstrb=4'b0101 -> read 0x00 returns 0x11BB33DD.
- Out of range with NUM_REGS=8: write to 0x20 -> bresp=10, all registers unchanged. Read 0x20 -> rresp=10, rdata=0.
- Channel ordering: W presented 3 cycles before AW, awready held -> write commits only after AW handshake, correct data. Repeat with AW first.
- Backpressure: bready=0 for 5 cycles -> bvalid/bresp stable, awready=wready=0. rready=0 for 5 cycles -> rdata stable, arready=0.
- Reset mid-write: assert areset after AW handshake but before W -> bvalid never asserts, target register stays 0. A subsequent full write works normally.

Source files
------------

// File: rtl/axi4_lite_reg_file.sv
// axi4_lite_reg_file
//   AXI4-Lite slave register bank. Holds NUM_REGS 32-bit registers with
//   byte-strobe writes and answers out-of-range accesses with SLVERR.
//   All register contents are exported in parallel on regs_flat.
//
// Ports
//   aclk, areset       : clock, synchronous active-high reset
//   aw*/w*/b*          : write address, write data, write response channels
//   ar*/r*             : read address, read data channels
//   regs_flat          : register k on bits [32k+31:32k]
//
// axi4_lite_reg_slot
//   One 32-bit register with per-byte write enables.

module axi4_lite_reg_slot (
  input  logic        aclk,
  input  logic        areset,
  input  logic        we,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] q
);
  always_ff @(posedge aclk) begin
    if (areset) begin
      q <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) q[8*b +: 8] <= wdata[8*b +: 8];
    end
  end
endmodule

module axi4_lite_reg_file #(
  parameter int NUM_REGS = 8
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [31:0]             awaddr,
  input  logic [2:0]              awprot,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [31:0]             wdata,
  input  logic [3:0]              wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [31:0]             araddr,
  input  logic [2:0]              arprot,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [31:0]             rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [32*NUM_REGS-1:0]  regs_flat
);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic { W_COLLECT, W_RESP } wstate_t;
  typedef enum logic { R_IDLE,    R_RESP } rstate_t;

  wstate_t wstate;
  rstate_t rstate;

  // Low until the first edge after reset so no ready is seen during reset.
  logic up;

  logic          aw_held, w_held, aw_ok;
  logic [IW-1:0] aw_idx;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;
  logic          commit;

  logic [NUM_REGS-1:0][31:0] regs;

  // Protection bits and byte offset carry no meaning for this bank.
  logic unused_bits;
  assign unused_bits = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

  // Word index = addr[31:2]; in range when all index bits above IW are zero.
  function automatic logic in_range(input logic [31:0] a);
    return a[31:IW+2] == '0;
  endfunction

  assign awready = up & (wstate == W_COLLECT) & ~aw_held;
  assign wready  = up & (wstate == W_COLLECT) & ~w_held;
  assign arready = up & (rstate == R_IDLE);
  assign commit  = (wstate == W_COLLECT) & aw_held & w_held;

  always_ff @(posedge aclk) begin
    if (areset) up <= 1'b0;
    else        up <= 1'b1;
  end

  // Write path: collect AW and W in any order, commit one edge later.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate  <= W_COLLECT;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_ok   <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
    end else begin
      case (wstate)
        W_COLLECT: begin
          if (aw_held && w_held) begin
            bvalid  <= 1'b1;
            bresp   <= aw_ok ? OKAY : SLVERR;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            wstate  <= W_RESP;
          end else begin
            if (awvalid && awready) begin
              aw_held <= 1'b1;
              aw_idx  <= awaddr[IW+1:2];
              aw_ok   <= in_range(awaddr);
            end
            if (wvalid && wready) begin
              w_held <= 1'b1;
              w_data <= wdata;
              w_strb <= wstrb;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            wstate <= W_COLLECT;
          end
        end
        default: wstate <= W_COLLECT;
      endcase
    end
  end

  // Register array; the commit edge and bvalid rising coincide.
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    axi4_lite_reg_slot u_slot (
      .aclk   (aclk),
      .areset (areset),
      .we     (commit & aw_ok & (aw_idx == IW'(k))),
      .wstrb  (w_strb),
      .wdata  (w_data),
      .q      (regs[k])
    );
  end

  assign regs_flat = regs;

  // Read path: sample on the AR edge, so a same-edge commit is not visible.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rstate <= R_IDLE;
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (arvalid && arready) begin
            if (in_range(araddr)) begin
              rdata <= regs[araddr[IW+1:2]];
              rresp <= OKAY;
            end else begin
              rdata <= '0;
              rresp <= SLVERR;
            end
            rvalid <= 1'b1;
            rstate <= R_RESP;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            rstate <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_reg_file.sv
// Self-checking bench for axi4_lite_reg_file (NUM_REGS = 8).
module tb_axi4_lite_reg_file;
  localparam int N = 8;

  logic          aclk = 1'b0;
  logic          areset;
  logic [31:0]   awaddr, wdata, araddr;
  logic [2:0]    awprot, arprot;
  logic [3:0]    wstrb;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [32*N-1:0] regs_flat;

  axi4_lite_reg_file #(.NUM_REGS(N)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_flat(regs_flat)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction level: pending AW/W captures, one response slot per path,
  // and a plain memory array updated by strobed bytes.
  logic [31:0] mem [N];
  bit          started = 0;
  bit          m_up = 0, aw_have = 0, w_have = 0;
  logic [31:0] h_addr, h_data;
  logic [3:0]  h_strb;
  bit          m_bvalid = 0, m_rvalid = 0;
  logic [1:0]  m_bresp = 0, m_rresp = 0;
  logic [31:0] m_rdata = 0;

  function automatic bit ok_addr(input logic [31:0] a);
    return (a >> 2) < N;
  endfunction

  task automatic model_step();
    bit awr, wr, arr;
    if (areset) begin
      m_up = 0; aw_have = 0; w_have = 0;
      m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
      for (int k = 0; k < N; k++) mem[k] = 0;
      started = 1;
      return;
    end
    awr = m_up && !m_bvalid && !aw_have;
    wr  = m_up && !m_bvalid && !w_have;
    arr = m_up && !m_rvalid;
    // read sees memory before any write landing on this same edge
    if (m_rvalid) begin
      if (rready) m_rvalid = 0;
    end else if (arr && arvalid) begin
      m_rvalid = 1;
      if (ok_addr(araddr)) begin m_rdata = mem[araddr[4:2]]; m_rresp = 2'b00; end
      else begin m_rdata = 0; m_rresp = 2'b10; end
    end
    if (aw_have && w_have) begin
      if (ok_addr(h_addr)) begin
        for (int b = 0; b < 4; b++)
          if (h_strb[b]) mem[h_addr[4:2]][8*b +: 8] = h_data[8*b +: 8];
        m_bresp = 2'b00;
      end else m_bresp = 2'b10;
      m_bvalid = 1; aw_have = 0; w_have = 0;
    end else if (m_bvalid && bready) m_bvalid = 0;
    if (awr && awvalid) begin aw_have = 1; h_addr = awaddr; end
    if (wr && wvalid)   begin w_have = 1; h_data = wdata; h_strb = wstrb; end
    m_up = 1;
  endtask

  initial forever begin
    @(posedge aclk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge aclk);
    if (started) begin
      chk("awready", awready, m_up && !m_bvalid && !aw_have);
      chk("wready",  wready,  m_up && !m_bvalid && !w_have);
      chk("arready", arready, m_up && !m_rvalid);
      chk("bvalid",  bvalid,  m_bvalid);
      chk("rvalid",  rvalid,  m_rvalid);
      if (m_bvalid) chk("bresp", bresp, m_bresp);
      if (m_rvalid) begin
        chk("rdata", rdata, m_rdata);
        chk("rresp", rresp, m_rresp);
      end
      for (int k = 0; k < N; k++)
        chk($sformatf("reg%0d", k), regs_flat[32*k +: 32], mem[k]);
    end
  end

  // ---------------- drivers ----------------
  bit rand_rdy = 0;
  initial forever begin
    @(negedge aclk);
    if (rand_rdy) begin
      bready = ($urandom % 3) != 0;
      rready = ($urandom % 3) != 0;
    end
  end

  // hold=1 returns as soon as bvalid is seen, leaving the response pending.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int ad, input int wd, input bit hold,
                          output int lat, output logic [1:0] resp);
    int cyc = 0;
    bit awd = 0, wdn = 0;
    lat = 0; resp = 2'bxx;
    while (!(awd && wdn)) begin
      awvalid = !awd && cyc >= ad; awaddr = a;
      wvalid  = !wdn && cyc >= wd; wdata = d; wstrb = s;
      @(posedge aclk);
      if (awvalid && awready) awd = 1;
      if (wvalid && wready)   wdn = 1;
      @(negedge aclk);
      cyc++;
      if (cyc > 60) begin chk("write_hs_timeout", 1, 0); awvalid = 0; wvalid = 0; return; end
    end
    awvalid = 0; wvalid = 0;
    while (!bvalid && lat < 20) begin @(negedge aclk); lat++; end
    if (!bvalid) begin chk("bvalid_timeout", 0, 1); return; end
    resp = bresp;
    if (hold) return;
    for (int i = 0; i < 60; i++) begin
      @(posedge aclk);
      if (bvalid && bready) begin @(negedge aclk); return; end
      @(negedge aclk);
    end
    chk("bresp_hs_timeout", 1, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input int dly, input bit hold,
                         output logic [31:0] d, output logic [1:0] resp);
    int cyc = 0;
    bit done = 0;
    d = 'x; resp = 2'bxx;
    repeat (dly) @(negedge aclk);
    while (!done) begin
      arvalid = 1; araddr = a;
      @(posedge aclk);
      if (arvalid && arready) done = 1;
      @(negedge aclk);
      cyc++;
      if (cyc > 60) begin chk("read_hs_timeout", 1, 0); arvalid = 0; return; end
    end
    arvalid = 0;
    for (int i = 0; i < 20 && !rvalid; i++) @(negedge aclk);
    if (!rvalid) begin chk("rvalid_timeout", 0, 1); return; end
    d = rdata; resp = rresp;
    if (hold) return;
    for (int i = 0; i < 60; i++) begin
      @(posedge aclk);
      if (rvalid && rready) begin @(negedge aclk); return; end
      @(negedge aclk);
    end
    chk("rdata_hs_timeout", 1, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic [1:0] r;
    logic [31:0] d, d0;
    logic [32*N-1:0] snap;

    areset = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    bready = 1; araddr = 0; arprot = 0; arvalid = 0; rready = 1;
    repeat (3) @(negedge aclk);
    chk("rst_awready", awready, 0); chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);   chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);     chk("rst_regs", (regs_flat == '0), 1);
    areset = 0;
    @(negedge aclk);
    chk("up_awready", awready, 1); chk("up_arready", arready, 1);

    // basic write, same-cycle AW+W
    do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 1, lat, r);
    chk("t1_lat", lat, 1); chk("t1_bresp", r, 0);
    chk("t1_reg1", regs_flat[63:32], 32'hDEADBEEF);
    @(negedge aclk);
    do_read(32'h04, 0, 0, d, r);
    chk("t1_rdata", d, 32'hDEADBEEF); chk("t1_rresp", r, 0);

    // byte strobes
    do_write(32'h00, 32'h11223344, 4'hF, 0, 0, 0, lat, r);
    do_write(32'h00, 32'hAABBCCDD, 4'b0101, 0, 0, 0, lat, r);
    do_read(32'h00, 0, 0, d, r);
    chk("t2_rdata", d, 32'h11BB33DD);

    // zero strobe: OKAY, no change
    do_write(32'h04, 32'h0, 4'h0, 0, 0, 0, lat, r);
    chk("t2z_bresp", r, 0); chk("t2z_reg1", regs_flat[63:32], 32'hDEADBEEF);

    // out of range
    snap = regs_flat;
    do_write(32'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0, lat, r);
    chk("t3_bresp", r, 2'b10); chk("t3_unchanged", (regs_flat == snap), 1);
    do_read(32'h20, 0, 0, d, r);
    chk("t3_rdata", d, 0); chk("t3_rresp", r, 2'b10);

    // channel ordering: W first, then AW first
    do_write(32'h08, 32'h12345678, 4'hF, 3, 0, 0, lat, r);
    do_read(32'h08, 0, 0, d, r); chk("t4_wfirst", d, 32'h12345678);
    do_write(32'h0C, 32'h9ABCDEF0, 4'hF, 0, 3, 0, lat, r);
    do_read(32'h0C, 0, 0, d, r); chk("t4_awfirst", d, 32'h9ABCDEF0);

    // write response backpressure
    bready = 0;
    do_write(32'h14, 32'h55AA55AA, 4'hF, 0, 0, 1, lat, r);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("t5_bvalid", bvalid, 1); chk("t5_bresp", bresp, 0);
      chk("t5_awready", awready, 0); chk("t5_wready", wready, 0);
    end
    bready = 1;
    @(negedge aclk);
    chk("t5_bdrop", bvalid, 0);
    @(negedge aclk);
    chk("t5_awback", awready, 1);

    // read response backpressure
    rready = 0;
    do_read(32'h14, 0, 1, d0, r);
    chk("t5_rd", d0, 32'h55AA55AA);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("t5_rdata", rdata, d0); chk("t5_arready", arready, 0);
    end
    rready = 1;
    @(negedge aclk);
    chk("t5_rdrop", rvalid, 0);

    // reset with AW held and W outstanding
    awvalid = 1; awaddr = 32'h10;
    for (int i = 0; i < 10 && !awready; i++) @(negedge aclk);
    @(negedge aclk);
    awvalid = 0;
    areset = 1;
    @(negedge aclk);
    areset = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("t6_bvalid", bvalid, 0); chk("t6_reg4", regs_flat[159:128], 0);
    end
    do_write(32'h10, 32'hCAFEF00D, 4'hF, 0, 0, 0, lat, r);
    chk("t6_bresp", r, 0);
    do_read(32'h10, 0, 0, d, r); chk("t6_rdata", d, 32'hCAFEF00D);

    // randomized concurrent traffic, narrow address range to force collisions
    rand_rdy = 1;
    for (int it = 0; it < 150; it++) begin
      logic [31:0] wa, ra, wd;
      logic [3:0] ws;
      int rd;
      logic [31:0] dd; logic [1:0] rr, br; int ll;
      wa = $urandom_range(0, 9) * 4 + $urandom_range(0, 3);
      ra = $urandom_range(0, 9) * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) wa[31] = 1'b1;
      if ($urandom_range(0, 15) == 0) ra[20] = 1'b1;
      wd = $urandom; ws = 4'($urandom);
      rd = $urandom_range(0, 3);
      fork
        do_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), 0, ll, br);
        do_read(ra, rd, 0, dd, rr);
      join
    end
    rand_rdy = 0;
    bready = 1; rready = 1;
    repeat (3) @(negedge aclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
